// File: rtl/sisc_pkg.sv
// Shared encodings for the SISC multi-cycle controller: opcodes, FSM states,
// ALU operation and PC source selects.
package sisc_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ALU_R = 4'h1,
        OP_ALU_I = 4'h2,
        OP_LOD   = 4'h3,
        OP_STR   = 4'h4,
        OP_BRA   = 4'h5,
        OP_BRR   = 4'h6,
        OP_BNE   = 4'h7,
        OP_HLT   = 4'hF
    } op_e;

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    typedef enum logic [1:0] {
        ALU_IDLE = 2'b00,
        ALU_RR   = 2'b01,
        ALU_IMM  = 2'b10,
        ALU_ADDR = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_INC = 2'b00,
        PC_ABS = 2'b01,
        PC_REL = 2'b10
    } pc_sel_e;

    function automatic logic op_legal(input logic [3:0] opc);
        return opc inside {OP_NOP, OP_ALU_R, OP_ALU_I, OP_LOD, OP_STR,
                           OP_BRA, OP_BRR, OP_BNE, OP_HLT};
    endfunction

endpackage

// File: rtl/sisc_br_eval.sv
// Conditional branch evaluation: BRA/BRR take on any masked status bit set,
// BNE takes when no masked status bit is set.
module sisc_br_eval
    import sisc_pkg::*;
#(
    parameter int W = 4
) (
    input  op_e          op,
    input  logic [W-1:0] mask,
    input  logic [W-1:0] stat,
    output logic         taken
);

    logic hit;

    assign hit = |(stat & mask);

    always_comb begin
        // NOTE: default assignment first, so every path drives taken and no latch is inferred.
        taken = 1'b0;
        case (op)
            OP_BRA, OP_BRR: taken = hit;
            OP_BNE:         taken = ~hit;
            default:        taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/sisc_mc_ctrl.sv
// Multi-cycle SISC control unit: fetch/decode/exec/mem/writeback sequencing.
// Define SISC_MC_TIMEOUT_EN to enable the memory-ack watchdog and bus_err.
module sisc_mc_ctrl
    import sisc_pkg::*;
#(
    parameter int OPC_W    = 4,
    parameter int MM_W     = 4,
    parameter int STAT_W   = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [MM_W-1:0]   mm,
    input  logic [STAT_W-1:0] stat,
    input  logic              imem_ack,
    input  logic              dmem_ack,
    output logic              imem_req,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic              ir_load,
    output logic              pc_write,
    output logic [1:0]        pc_sel,
    output logic              rf_we,
    output logic [1:0]        alu_op,
    output logic              wb_sel,
    output logic              stat_en,
    output logic              halted,
    output logic              bus_err,
    output logic              ill_op
);

    if (MM_W != STAT_W || WAIT_MAX < 1) begin : g_cfg_check
        $error("sisc_mc_ctrl: MM_W must equal STAT_W and WAIT_MAX must be >= 1");
    end

    state_e          state;
    op_e             op_q;
    logic [MM_W-1:0] mm_q;
    logic [3:0]      opc4;
    logic            taken;
    logic            timeout;

    assign opc4 = 4'(opcode);

    sisc_br_eval #(.W(STAT_W)) u_br_eval (
        .op    (op_q),
        .mask  (mm_q),
        .stat  (stat),
        .taken (taken)
    );

`ifdef SISC_MC_TIMEOUT_EN
    localparam int            CW      = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_MAX);

    logic          waiting;
    logic          ack;
    logic [CW-1:0] wait_cnt;

    assign waiting = (state == S_FETCH) || (state == S_MEM);
    assign ack     = (state == S_FETCH) ? imem_ack : dmem_ack;
    // Timeout fires only once the count has reached WAIT_MAX and still no ack.
    assign timeout = waiting && !ack && (wait_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f)
            wait_cnt <= '0;
        else if (waiting && !ack)
            wait_cnt <= wait_cnt + 1'b1;
        else
            wait_cnt <= '0;
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f)
            bus_err <= 1'b0;
        else if (timeout)
            bus_err <= 1'b1;
    end
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    // Outputs are registered: each transition loads the strobes of the state being entered.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state    <= S_RESET;
            op_q     <= OP_NOP;
            mm_q     <= '0;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            ir_load  <= 1'b0;
            pc_write <= 1'b0;
            pc_sel   <= PC_INC;
            rf_we    <= 1'b0;
            alu_op   <= ALU_IDLE;
            wb_sel   <= 1'b0;
            stat_en  <= 1'b0;
            halted   <= 1'b0;
            ill_op   <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; strobes default low so each lasts exactly one state.
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            ir_load  <= 1'b0;
            pc_write <= 1'b0;
            pc_sel   <= PC_INC;
            rf_we    <= 1'b0;
            alu_op   <= ALU_IDLE;
            wb_sel   <= 1'b0;
            stat_en  <= 1'b0;

            case (state)
                S_RESET: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end

                S_FETCH: begin
                    if (imem_ack) begin
                        state    <= S_DECODE;
                        ir_load  <= 1'b1;
                        pc_write <= 1'b1;
                    end else if (timeout) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end

                S_DECODE: begin
                    op_q <= op_legal(opc4) ? op_e'(opc4) : OP_NOP;
                    mm_q <= mm;
                    if (!op_legal(opc4))
                        ill_op <= 1'b1;
                    if (opc4 == OP_HLT) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= S_EXEC;
                        case (opc4)
                            OP_ALU_R: begin
                                alu_op  <= ALU_RR;
                                stat_en <= 1'b1;
                            end
                            OP_ALU_I: begin
                                alu_op  <= ALU_IMM;
                                stat_en <= 1'b1;
                            end
                            OP_LOD, OP_STR: alu_op <= ALU_ADDR;
                            default:        alu_op <= ALU_IDLE;
                        endcase
                    end
                end

                S_EXEC: begin
                    if (op_q == OP_LOD || op_q == OP_STR) begin
                        state    <= S_MEM;
                        dmem_req <= 1'b1;
                        dmem_we  <= (op_q == OP_STR);
                    end else begin
                        state <= S_WB;
                        if (op_q == OP_ALU_R || op_q == OP_ALU_I)
                            rf_we <= 1'b1;
                        if (taken) begin
                            pc_write <= 1'b1;
                            pc_sel   <= (op_q == OP_BRR) ? PC_REL : PC_ABS;
                        end
                    end
                end

                S_MEM: begin
                    if (dmem_ack) begin
                        state <= S_WB;
                        if (op_q == OP_LOD) begin
                            rf_we  <= 1'b1;
                            wb_sel <= 1'b1;
                        end
                    end else if (timeout) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        dmem_req <= 1'b1;
                        dmem_we  <= (op_q == OP_STR);
                    end
                end

                S_WB: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end

                S_HALT:  halted <= 1'b1;

                default: state <= S_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_sisc_mc_ctrl.sv
// Randomised scoreboard bench for sisc_mc_ctrl: per-instruction effect records
// predicted from the ISA rules and compared against what the monitor observes.
module tb_sisc_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_f = 1'b0;
    logic [3:0] opcode = '0, mm = '0, stat = '0;
    logic       imem_ack = 1'b0, dmem_ack = 1'b0;
    logic       imem_req, dmem_req, dmem_we, ir_load, pc_write, rf_we;
    logic [1:0] pc_sel, alu_op;
    logic       wb_sel, stat_en, halted, bus_err, ill_op;

    sisc_mc_ctrl dut (
        .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_load(ir_load), .pc_write(pc_write), .pc_sel(pc_sel), .rf_we(rf_we),
        .alu_op(alu_op), .wb_sel(wb_sel), .stat_en(stat_en), .halted(halted),
        .bus_err(bus_err), .ill_op(ill_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        int alu_op, stat_en, rf_we, wb_sel, br, pc_sel, we, mem;
        int fetch, fetch_ok, busy, ill, halted;
    } rec_t;

    rec_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   rec_idx = 0;
    bit   mon_en = 1'b0;
    bit   model_ill = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, expv);
    endtask

    function automatic logic [15:0] outs_vec();
        return {imem_req, dmem_req, dmem_we, ir_load, pc_write, pc_sel, rf_we,
                alu_op, wb_sel, stat_en, halted, bus_err, ill_op};
    endfunction

    // Reference model: effects of one instruction from the ISA description.
    function automatic rec_t model(input logic [3:0] op, input logic [3:0] m,
                                   input logic [3:0] s, input int d, input int dd,
                                   input bit ill);
        rec_t r = '{default: 0};
        bit hit = (s & m) != 4'd0;
        r.fetch = d + 1;
        r.fetch_ok = 1;
        r.ill = ill;
        case (op)
            4'h1: begin r.alu_op = 1; r.stat_en = 1; r.rf_we = 1; end
            4'h2: begin r.alu_op = 2; r.stat_en = 1; r.rf_we = 1; end
            4'h3: begin r.alu_op = 3; r.rf_we = 1; r.wb_sel = 1; r.mem = dd + 1; end
            4'h4: begin r.alu_op = 3; r.we = 1; r.mem = dd + 1; end
            4'h5: begin r.br = hit;  r.pc_sel = hit ? 1 : 0; end
            4'h6: begin r.br = hit;  r.pc_sel = hit ? 2 : 0; end
            4'h7: begin r.br = !hit; r.pc_sel = !hit ? 1 : 0; end
            4'hF: r.halted = 1;
            default: ;
        endcase
        r.busy = (op == 4'hF) ? 1 : 3 + r.mem;
        return r;
    endfunction

    task automatic close_rec(input rec_t got);
        rec_t e;
        string p;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL rec_unexpected: got an instruction record, required none queued");
            return;
        end
        e = exp_q.pop_front();
        rec_idx++;
        p = $sformatf("i%0d_", rec_idx);
        check({p, "alu_op"},   got.alu_op,   e.alu_op);
        check({p, "stat_en"},  got.stat_en,  e.stat_en);
        check({p, "rf_we"},    got.rf_we,    e.rf_we);
        check({p, "wb_sel"},   got.wb_sel,   e.wb_sel);
        check({p, "br_write"}, got.br,       e.br);
        check({p, "pc_sel"},   got.pc_sel,   e.pc_sel);
        check({p, "dmem_we"},  got.we,       e.we);
        check({p, "mem_cyc"},  got.mem,      e.mem);
        check({p, "fetch_cyc"}, got.fetch,   e.fetch);
        check({p, "fetch_str"}, got.fetch_ok, e.fetch_ok);
        check({p, "busy_cyc"}, got.busy,     e.busy);
        check({p, "ill_op"},   got.ill,      e.ill);
        check({p, "halted"},   got.halted,   e.halted);
    endtask

    // Monitor: a record spans from one ir_load pulse to the next (or halt).
    initial begin : monitor
        rec_t cur;
        bit   open = 1'b0;
        bit   prev_halt = 1'b0;
        int   fetch_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_f || !mon_en) begin
                open = 1'b0;
                prev_halt = 1'b0;
                fetch_cnt = 0;
            end else begin
                if (ir_load || (halted && !prev_halt)) begin
                    if (open) begin
                        cur.ill = ill_op;
                        cur.halted = halted;
                        close_rec(cur);
                    end
                    open = 1'b0;
                end
                if (ir_load) begin
                    cur = '{default: 0};
                    cur.fetch = fetch_cnt;
                    cur.fetch_ok = pc_write && pc_sel == 2'b00 && !imem_req;
                    fetch_cnt = 0;
                    open = 1'b1;
                end
                prev_halt = halted;
                if (imem_req) fetch_cnt++;
                if (open && !imem_req) begin
                    cur.busy++;
                    if (alu_op != 2'b00) cur.alu_op = alu_op;
                    if (stat_en) cur.stat_en = 1;
                    if (rf_we) begin cur.rf_we = 1; cur.wb_sel = wb_sel; end
                    if (pc_write && !ir_load) begin cur.br = 1; cur.pc_sel = pc_sel; end
                    if (dmem_req) begin cur.mem++; if (dmem_we) cur.we = 1; end
                end
            end
        end
    end

    task automatic wait_high(input bit dmem, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dmem ? dmem_req : imem_req) && n < 64);
        if (!(dmem ? dmem_req : imem_req)) begin
            n_checks++;
            $display("FAIL wait_%s: request never rose, required within 64 cycles",
                     dmem ? "dmem_req" : "imem_req");
        end
    endtask

    task automatic fetch(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s,
                         input int d, output int n);
        wait_high(1'b0, n);
        opcode = op;
        mm = m;
        stat = s;
        repeat (d) @(negedge clk);
        imem_ack = 1'b1;
        @(posedge clk);
        #1 imem_ack = 1'b0;
    endtask

    task automatic mem_phase(input int dd);
        int n;
        wait_high(1'b1, n);
        repeat (dd) @(negedge clk);
        dmem_ack = 1'b1;
        @(posedge clk);
        #1 dmem_ack = 1'b0;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s,
                             input int d, input int dd, input bit push, output int n);
        if (push) begin
            if (!((op <= 4'h7) || (op == 4'hF))) model_ill = 1'b1;
            exp_q.push_back(model(op, m, s, d, dd, model_ill));
        end
        fetch(op, m, s, d, n);
        @(posedge clk);
        #1;
        opcode = 4'($urandom);
        mm = 4'($urandom);
        if (op == 4'h3 || op == 4'h4) mem_phase(dd);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int n;
        int ok;
        int pick;
        logic [3:0] op;

        // Phase A: reset, directed cases, random program, halt.
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs_vec(), 16'h0);
        rst_f = 1'b1;
        #1 check("reset_cycle_idle", imem_req, 1'b0);

        run_instr(4'h1, 4'h0, 4'h0, 0, 0, 1'b1, n);
        check("first_fetch_cycle", n, 1);
        run_instr(4'h3, 4'h0, 4'h0, 1, 2, 1'b1, n);
        run_instr(4'h5, 4'b0010, 4'b0010, 0, 0, 1'b1, n);
        run_instr(4'h5, 4'b0010, 4'b0001, 0, 0, 1'b1, n);
        run_instr(4'h6, 4'b1100, 4'b0100, 2, 0, 1'b1, n);
        run_instr(4'h7, 4'b1000, 4'b0111, 0, 0, 1'b1, n);
        run_instr(4'h7, 4'b0011, 4'b0001, 0, 0, 1'b1, n);
        run_instr(4'h4, 4'h0, 4'h0, 0, 0, 1'b1, n);
        run_instr(4'hA, 4'hF, 4'hF, 0, 0, 1'b1, n);
        for (int i = 0; i < 40; i++) begin
            pick = $urandom_range(0, 9);
            op = (pick < 8) ? 4'(pick) : ((pick == 8) ? 4'hA : 4'hC);
            run_instr(op, 4'($urandom), 4'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'b1, n);
        end
        run_instr(4'hF, 4'h0, 4'h0, 1, 0, 1'b1, n);

        ok = 0;
        repeat (10) begin
            @(negedge clk);
            if (halted && !imem_req && !dmem_req && !rf_we && !pc_write) ok++;
        end
        check("halt_permanent", ok, 10);
        check("queue_drained", exp_q.size(), 0);
        check("ill_op_sticky", ill_op, 1'b1);
        mon_en = 1'b0;

        // Phase B: asynchronous reset during a data request.
        rst_f = 1'b0;
        #1 check("async_reset_from_halt", outs_vec(), 16'h0);
        @(posedge clk);
        #1 rst_f = 1'b1;
        run_instr(4'hA, 4'h0, 4'h0, 0, 0, 1'b0, n);
        fetch(4'h3, 4'h0, 4'h0, 0, n);
        @(posedge clk);
        #1;
        wait_high(1'b1, n);
        @(posedge clk);
        #1 check("mem_req_held", {dmem_req, dmem_we, ill_op}, 3'b101);
        rst_f = 1'b0;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        #1 check("async_reset_mid_mem", outs_vec(), 16'h0);
        @(posedge clk);
        #1 rst_f = 1'b1;
        @(negedge clk);
        check("reset_cycle_ignores_ack", {imem_req, ir_load, dmem_req}, 3'b000);
        @(posedge clk);
        #1 begin
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
        end
        @(negedge clk);
        check("fetch_resumes", {imem_req, ir_load}, 2'b10);
        imem_ack = 1'b1;
        @(posedge clk);
        #1 imem_ack = 1'b0;
        check("fetch_after_reset", {ir_load, pc_write, imem_req}, 3'b110);

`ifdef SISC_MC_TIMEOUT_EN
        // Phase C: ack on the last allowed cycle, then a fetch that never completes.
        @(negedge clk);
        rst_f = 1'b0;
        @(negedge clk);
        rst_f = 1'b1;
        fetch(4'h0, 4'h0, 4'h0, 15, n);
        check("ack_at_wait_max", {ir_load, bus_err, halted}, 3'b100);
        wait_high(1'b0, n);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!imem_req) break;
            n++;
        end
        check("timeout_req_cycles", n, 16);
        check("timeout_flags", {bus_err, halted, imem_req}, 3'b110);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
